// File: rtl/nd_1to2_pkg.sv
// Shared constants, FSM state types and compare/redundancy helpers for the nd_1to2 router node.
// The optional redundancy check is enabled by defining NS_ND_REDUN_CHK_EN.
package nd_1to2_pkg;

    localparam int NS_GT_OP  = 0;
    localparam int NS_GTE_OP = 1;
    localparam int NS_LT_OP  = 2;
    localparam int NS_LTE_OP = 3;
    localparam int NS_EQ_OP  = 4;
    localparam int NS_NEQ_OP = 5;

    localparam int NS_ON    = 1;
    localparam int NS_OFF   = 0;
    localparam int NS_TRUE  = 1;
    localparam int NS_FALSE = 0;

    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic [1:0] {IN_IDLE, IN_ACK, IN_WAIT_LOW} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT_ACK, OUT_WAIT_LOW} out_state_t;

    // Unsigned compare; unknown operator codes evaluate false.
    function automatic logic ns_cmp(input logic [31:0] val, input int op,
                                    input logic [31:0] ref_val);
        case (op)
            NS_GT_OP:  return val >  ref_val;
            NS_GTE_OP: return val >= ref_val;
            NS_LT_OP:  return val <  ref_val;
            NS_LTE_OP: return val <= ref_val;
            NS_EQ_OP:  return val == ref_val;
            NS_NEQ_OP: return val != ref_val;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic ns_range_cmp(input logic [31:0] val,
                                          input int op1, input logic [31:0] ref1,
                                          input logic is_range,
                                          input int op2, input logic [31:0] ref2);
        if (is_range)
            return ns_cmp(val, op1, ref1) && ns_cmp(val, op2, ref2);
        return ns_cmp(val, op1, ref1);
    endfunction

    function automatic logic [31:0] calc_redun(input logic [31:0] src,
                                               input logic [31:0] dst,
                                               input logic [31:0] dat);
        return src + dst + dat;
    endfunction

endpackage

// File: rtl/nd_hs_sync.sv
// Two-flop synchroniser for one asynchronous handshake line.
module nd_hs_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use non-blocking assignments so meta and q sample the same edge without ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nd_1to2.sv
// One-input, two-output message router with a single-entry buffer and four-phase handshakes.
// Define NS_ND_REDUN_CHK_EN to drop messages whose redundancy field mismatches and export err_redun.
module nd_1to2
    import nd_1to2_pkg::*;
#(
    parameter int          OPER_1    = NS_GT_OP,
    parameter int unsigned REF_VAL_1 = 0,
    parameter int          IS_RANGE  = NS_FALSE,
    parameter int          OPER_2    = NS_GT_OP,
    parameter int unsigned REF_VAL_2 = 0,
    parameter int          ASZ       = NS_ADDRESS_SIZE,
    parameter int          DSZ       = NS_DATA_SIZE,
    parameter int          RSZ       = NS_REDUN_SIZE
) (
`ifdef NS_ND_REDUN_CHK_EN
    output logic           err_redun,
`endif
    input  logic           clk,
    input  logic           reset,
    input  logic           i0_req_in,
    output logic           i0_ack_out,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    output logic           o0_req_out,
    input  logic           o0_ack_in,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o1_req_out,
    input  logic           o1_ack_in,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic [RSZ-1:0] o1_red
);

    logic ckd_req, ckd_ack0, ckd_ack1;

    nd_hs_sync u_sync_req  (.clk(clk), .reset(reset), .d(i0_req_in), .q(ckd_req));
    nd_hs_sync u_sync_ack0 (.clk(clk), .reset(reset), .d(o0_ack_in), .q(ckd_ack0));
    nd_hs_sync u_sync_ack1 (.clk(clk), .reset(reset), .d(o1_ack_in), .q(ckd_ack1));

    in_state_t      in_state;
    out_state_t     out_state;
    logic           buf_full, buf_sel;
    logic [ASZ-1:0] buf_src, buf_dst;
    logic [DSZ-1:0] buf_dat;
    logic [RSZ-1:0] buf_red;

    logic capture, set_full, clr_full, cur_ack;

    assign capture  = (in_state == IN_IDLE) && ckd_req && !i0_ack_out && !buf_full;
    assign cur_ack  = buf_sel ? ckd_ack1 : ckd_ack0;
    assign clr_full = (out_state == OUT_WAIT_LOW) && !cur_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state   <= IN_IDLE;
            i0_ack_out <= 1'b0;
            buf_sel    <= 1'b0;
            // NOTE: the buffer is a handful of flops, so it is reset to keep outputs deterministic after reset.
            buf_src    <= '0;
            buf_dst    <= '0;
            buf_dat    <= '0;
            buf_red    <= '0;
        end else begin
            case (in_state)
                IN_IDLE: begin
                    if (capture) begin
                        buf_src  <= i0_src;
                        buf_dst  <= i0_dst;
                        buf_dat  <= i0_dat;
                        buf_red  <= i0_red;
                        buf_sel  <= !ns_range_cmp(32'(i0_dst), OPER_1, REF_VAL_1,
                                                  IS_RANGE != 0, OPER_2, REF_VAL_2);
                        in_state <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    i0_ack_out <= 1'b1;
                    in_state   <= IN_WAIT_LOW;
                end
                default: begin
                    if (!ckd_req) begin
                        i0_ack_out <= 1'b0;
                        in_state   <= IN_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef NS_ND_REDUN_CHK_EN
    // The mismatch is registered at capture and resolved in IN_ACK, one cycle later.
    logic red_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_bad   <= 1'b0;
            err_redun <= 1'b0;
        end else begin
            if (capture)
                red_bad <= (i0_red != RSZ'(calc_redun(32'(i0_src), 32'(i0_dst), 32'(i0_dat))));
            if ((in_state == IN_ACK) && red_bad)
                err_redun <= 1'b1;
        end
    end

    assign set_full = (in_state == IN_ACK) && !red_bad;
`else
    assign set_full = capture;
`endif

    // A new capture wins over a same-cycle release of the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            buf_full <= 1'b0;
        else if (set_full)
            buf_full <= 1'b1;
        else if (clr_full)
            buf_full <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state  <= OUT_IDLE;
            o0_req_out <= 1'b0;
            o1_req_out <= 1'b0;
            o0_src     <= '0;
            o0_dst     <= '0;
            o0_dat     <= '0;
            o0_red     <= '0;
            o1_src     <= '0;
            o1_dst     <= '0;
            o1_dat     <= '0;
            o1_red     <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (buf_full) begin
                        if (buf_sel) begin
                            o1_src <= buf_src;
                            o1_dst <= buf_dst;
                            o1_dat <= buf_dat;
                            o1_red <= buf_red;
                        end else begin
                            o0_src <= buf_src;
                            o0_dst <= buf_dst;
                            o0_dat <= buf_dat;
                            o0_red <= buf_red;
                        end
                        out_state <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (buf_sel)
                        o1_req_out <= 1'b1;
                    else
                        o0_req_out <= 1'b1;
                    out_state <= OUT_WAIT_ACK;
                end
                OUT_WAIT_ACK: begin
                    if (cur_ack) begin
                        o0_req_out <= 1'b0;
                        o1_req_out <= 1'b0;
                        out_state  <= OUT_WAIT_LOW;
                    end
                end
                default: begin
                    if (!cur_ack)
                        out_state <= OUT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nd_1to2.sv
// Self-checking bench for nd_1to2: instance 0 routes dst>2 to o0, instance 1 routes 1<dst<4 to o0.
module tb_nd_1to2;
    import nd_1to2_pkg::*;

    localparam int ASZ = NS_ADDRESS_SIZE;
    localparam int DSZ = NS_DATA_SIZE;
    localparam int RSZ = NS_REDUN_SIZE;
    localparam int MW  = 2 * ASZ + DSZ + RSZ;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     in_req, in_ack;
    logic [ASZ-1:0] in_src [2];
    logic [ASZ-1:0] in_dst [2];
    logic [DSZ-1:0] in_dat [2];
    logic [RSZ-1:0] in_red [2];
    logic [3:0]     o_req, o_ack;
    logic [ASZ-1:0] o_src [4];
    logic [ASZ-1:0] o_dst [4];
    logic [DSZ-1:0] o_dat [4];
    logic [RSZ-1:0] o_red [4];
`ifdef NS_ND_REDUN_CHK_EN
    logic [1:0]     err_redun;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_dly [4] = '{2, 2, 2, 2};
    int rx_cnt  [4] = '{0, 0, 0, 0};
    int rise_cyc[4] = '{0, 0, 0, 0};
    int req_cyc [2] = '{0, 0};
    logic [MW-1:0] exp_q[4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nd_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(2)) u_dut0 (
`ifdef NS_ND_REDUN_CHK_EN
        .err_redun(err_redun[0]),
`endif
        .clk(clk), .reset(reset),
        .i0_req_in(in_req[0]), .i0_ack_out(in_ack[0]),
        .i0_src(in_src[0]), .i0_dst(in_dst[0]), .i0_dat(in_dat[0]), .i0_red(in_red[0]),
        .o0_req_out(o_req[0]), .o0_ack_in(o_ack[0]),
        .o0_src(o_src[0]), .o0_dst(o_dst[0]), .o0_dat(o_dat[0]), .o0_red(o_red[0]),
        .o1_req_out(o_req[1]), .o1_ack_in(o_ack[1]),
        .o1_src(o_src[1]), .o1_dst(o_dst[1]), .o1_dat(o_dat[1]), .o1_red(o_red[1])
    );

    nd_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(1), .IS_RANGE(NS_TRUE),
              .OPER_2(NS_LT_OP), .REF_VAL_2(4)) u_dut1 (
`ifdef NS_ND_REDUN_CHK_EN
        .err_redun(err_redun[1]),
`endif
        .clk(clk), .reset(reset),
        .i0_req_in(in_req[1]), .i0_ack_out(in_ack[1]),
        .i0_src(in_src[1]), .i0_dst(in_dst[1]), .i0_dat(in_dat[1]), .i0_red(in_red[1]),
        .o0_req_out(o_req[2]), .o0_ack_in(o_ack[2]),
        .o0_src(o_src[2]), .o0_dst(o_dst[2]), .o0_dat(o_dat[2]), .o0_red(o_red[2]),
        .o1_req_out(o_req[3]), .o1_ack_in(o_ack[3]),
        .o1_src(o_src[3]), .o1_dst(o_dst[3]), .o1_dat(o_dat[3]), .o1_red(o_red[3])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Routing rule of each instance, straight from its configuration.
    function automatic int route(input int k, input int dst);
        if (k == 0) return (dst > 2) ? 0 : 1;
        return (dst > 1 && dst < 4) ? 0 : 1;
    endfunction

    function automatic logic [MW-1:0] obs(input int c);
        return {o_src[c], o_dst[c], o_dat[c], o_red[c]};
    endfunction

    function automatic int qtotal();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    endfunction

    // Compare process: every new downstream request must match the head of the expected queue.
    initial begin
        logic [3:0] seen = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (o_req[c] && !seen[c]) begin
                    rx_cnt[c]++;
                    rise_cyc[c] = cyc;
                    check($sformatf("req_expected_ch%0d", c), 64'(exp_q[c].size() > 0), 64'd1);
                    if (exp_q[c].size() > 0) begin
                        check($sformatf("fields_ch%0d", c), 64'(obs(c)), 64'(exp_q[c][0]));
                        void'(exp_q[c].pop_front());
                    end
                end
                seen[c] = o_req[c];
            end
            for (int k = 0; k < 2; k++)
                if (o_req[2*k] || o_req[2*k+1])
                    check($sformatf("single_req_%0d", k), 64'(o_req[2*k] && o_req[2*k+1]), 64'd0);
        end
    end

    // Downstream sinks: acknowledge after ack_dly cycles, release once req drops.
    initial begin
        int cnt[4] = '{0, 0, 0, 0};
        o_ack = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (o_req[c] && !o_ack[c]) begin
                    if (cnt[c] >= ack_dly[c]) begin
                        o_ack[c] = 1'b1;
                        cnt[c]   = 0;
                    end else begin
                        cnt[c]++;
                    end
                end else if (!o_req[c]) begin
                    o_ack[c] = 1'b0;
                    cnt[c]   = 0;
                end
            end
        end
    end

    task automatic wait_ack(input int k, input logic level, input string name);
        int n = 0;
        while (in_ack[k] !== level && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(in_ack[k]), 64'(level));
    endtask

    task automatic present(input int k, input int src, input int dst, input int dat, input bit corrupt);
        logic [RSZ-1:0] r;
        r = RSZ'(src + dst + dat) + RSZ'(corrupt);
        in_src[k] = ASZ'(src);
        in_dst[k] = ASZ'(dst);
        in_dat[k] = DSZ'(dat);
        in_red[k] = r;
        if (!corrupt)
            exp_q[2*k + route(k, dst)].push_back({ASZ'(src), ASZ'(dst), DSZ'(dat), r});
        in_req[k]  = 1'b1;
        req_cyc[k] = cyc;
    endtask

    task automatic send(input int k, input int src, input int dst, input int dat, input bit corrupt);
        wait_ack(k, 1'b0, "ack_idle");
        present(k, src, dst, dat, corrupt);
        wait_ack(k, 1'b1, "ack_rise");
        in_req[k] = 1'b0;
        wait_ack(k, 1'b0, "ack_fall");
    endtask

    task automatic drain();
        int n = 0;
        while ((qtotal() != 0 || o_req != 4'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_queues", 64'(qtotal()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        in_req = '0;
        for (int k = 0; k < 2; k++) begin
            in_src[k] = '0;
            in_dst[k] = '0;
            in_dat[k] = '0;
            in_red[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_i0_ack", 64'(in_ack), 64'd0);
        check("rst_o_req", 64'(o_req), 64'd0);
        check("rst_o0_fields", 64'(obs(0)), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // GT 2: dst=3 goes to o0; latency is two sync flops plus at least three clocks.
        send(0, 1, 3, 5, 1'b0);
        drain();
        check("gt_o0_count", 64'(rx_cnt[0]), 64'd1);
        check("gt_o1_count", 64'(rx_cnt[1]), 64'd0);
        check("gt_o0_dat", 64'(o_dat[0]), 64'd5);
        check("latency_min", 64'((rise_cyc[0] - req_cyc[0]) >= 5), 64'd1);

        // dst=1 and the boundary dst=2 both go to o1.
        send(0, 2, 1, 6, 1'b0);
        send(0, 2, 2, 7, 1'b0);
        drain();
        check("gt_o1_count2", 64'(rx_cnt[1]), 64'd2);
        check("gt_o0_count2", 64'(rx_cnt[0]), 64'd1);
        check("gt_o1_dst", 64'(o_dst[1]), 64'd2);

        // Range GT 1 AND LT 4 sweep.
        for (int d = 0; d < 6; d++)
            send(1, 3, d, 16 + d, 1'b0);
        drain();
        check("range_o0_count", 64'(rx_cnt[2]), 64'd2);
        check("range_o1_count", 64'(rx_cnt[3]), 64'd4);
        check("range_o1_last_dat", 64'(o_dat[3]), 64'd21);

        // Stall: o0 held off for 50 clocks while a second message arrives.
        ack_dly[0] = 50;
        send(0, 4, 3, 33, 1'b0);
        present(0, 4, 5, 34, 1'b0);
        repeat (10) @(negedge clk);
        check("stall_i0_ack", 64'(in_ack[0]), 64'd0);
        check("stall_o0_req", 64'(o_req[0]), 64'd1);
        wait_ack(0, 1'b1, "stall_ack_rise");
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "stall_ack_fall");
        ack_dly[0] = 2;
        drain();
        check("stall_o0_count", 64'(rx_cnt[0]), 64'd3);

        // Reset while o1 request is pending.
        ack_dly[1] = 100000;
        send(0, 5, 0, 68, 1'b0);
        begin
            int n = 0;
            while (!o_req[1] && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("o1_req_before_rst", 64'(o_req[1]), 64'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_async_o_req", 64'(o_req), 64'd0);
        check("rst_async_i0_ack", 64'(in_ack), 64'd0);
        ack_dly[1] = 2;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(0, 6, 4, 85, 1'b0);
        drain();
        check("post_rst_o0_count", 64'(rx_cnt[0]), 64'd4);
        check("post_rst_o1_count", 64'(rx_cnt[1]), 64'd3);

`ifdef NS_ND_REDUN_CHK_EN
        // Corrupted redundancy: acked upstream, dropped, sticky error flag.
        send(0, 1, 3, 9, 1'b1);
        repeat (20) @(negedge clk);
        check("redun_err_set", 64'(err_redun[0]), 64'd1);
        check("redun_dropped", 64'(rx_cnt[0]), 64'd4);
        send(0, 1, 3, 10, 1'b0);
        drain();
        check("redun_good_fwd", 64'(rx_cnt[0]), 64'd5);
        check("redun_err_sticky", 64'(err_redun[0]), 64'd1);
        reset = 1'b0;
        #1;
        check("redun_err_rst", 64'(err_redun[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nd_1to2.md
Name: nd_1to2

Overview:
- One-input, two-output message router node.
- Accepts a message (src, dst, dat, red) on input channel i0 over a four-phase req/ack handshake and holds it in a single-entry buffer.
- Forwards it unchanged on o0 when dst satisfies the configured compare, otherwise on o1.
- Placed between a source channel and two sink channels; it is the node a 1-to-2 debug harness drives and checks.

Parameters:
- OPER_1, `NS_GT_OP: compare operator for the first condition (GT/GTE/LT/LTE/EQ/NEQ codes).
- REF_VAL_1, 0: reference value for the first condition.
- IS_RANGE, `NS_FALSE: when true, the route condition is cond1 AND cond2.
- OPER_2, `NS_GT_OP: compare operator for the second condition.
- REF_VAL_2, 0: reference value for the second condition.
- ASZ, `NS_ADDRESS_SIZE: address width.
- DSZ, `NS_DATA_SIZE: data width.
- RSZ, `NS_REDUN_SIZE: redundancy width.

Ports:
- clk  in  1  single node clock.
- reset  in  1  asynchronous, active-low reset.
- i0_req_in  in  1  upstream request (asynchronous domain).
- i0_ack_out  out  1  upstream acknowledge.
- i0_src, i0_dst  in  ASZ  incoming source and destination addresses.
- i0_dat  in  DSZ  incoming data.
- i0_red  in  RSZ  incoming redundancy.
- o0_req_out, o1_req_out  out  1  downstream requests.
- o0_ack_in, o1_ack_in  in  1  downstream acknowledges (asynchronous).
- o0_src/o0_dst/o0_dat/o0_red, o1_src/o1_dst/o1_dat/o1_red  out  ASZ/ASZ/DSZ/RSZ  outgoing message fields.

Behaviour:
- One clock; reset asynchronous, active-low.
- i0_req_in, o0_ack_in and o1_ack_in pass through 2-flop synchronisers (ckd_* signals). All handshake decisions use the synchronised values.
- Reset values:
  - All req/ack outputs 0.
  - Buffer empty; both FSMs in IDLE.
  - Message output registers 0.
- Input FSM:
  - IDLE: when ckd_req=1, i0_ack_out=0 and buffer empty, latch all four fields in one cycle, set buf_full and sel. Go to ACK.
  - sel = 0 (route to o0) when the range compare on dst is true, else sel = 1.
  - ACK: drive i0_ack_out=1 on the next cycle. Wait for ckd_req=0, then drop ack the following cycle and return to IDLE.
  - A req that is held high after ack does not cause a double capture.
- Output FSM:
  - IDLE: when buf_full, present the buffered fields on o[sel]. Assert o[sel]_req_out one cycle after the fields are stable. Go to WAIT_ACK.
  - WAIT_ACK: on ckd_ack[sel]=1, drop req. Go to WAIT_LOW.
  - WAIT_LOW: on ckd_ack[sel]=0, clear buf_full. Go to IDLE.
  - The non-selected output's req stays 0. Its fields hold their last value.
- Throughput: upstream may complete its handshake while downstream is pending. The next capture waits for buf_full=0. No message is lost or duplicated.
- Simultaneous events: a buf_full clear and a new capture in the same cycle is allowed; the capture takes priority for setting buf_full. Latency from ckd_req rising to o_req rising is 3 clk minimum.
- Compare rules:
  - Unsigned, dst zero-extended to 32 bits.
  - IS_RANGE=false: only cond1 is used.
  - Unknown operator code evaluates false.
- Reset mid-handshake: all FSMs return to IDLE, reqs/acks go low, and the buffered message is discarded.

Optional Feature:
- Macro NS_ND_REDUN_CHK_EN.
- Defined:
  - On capture, i0_red is compared with calc_redun(src, dst, dat), registered one cycle.
  - On mismatch, the message is acked upstream but dropped: buf_full is not set.
  - A sticky err_redun flag is exported on extra output port err_redun (1 bit, reset 0).
- Undefined:
  - No check; messages are forwarded regardless of red.
  - The err_redun port is absent.

Decomposition:
- Shared package/header (hglobal.v):
  - Operator codes NS_GT_OP etc., NS_ON/NS_OFF, NS_TRUE/NS_FALSE.
  - Size defaults, channel declare/assign macros.
  - The NS_RANGE_CMP_OP macro.
  - Local FSM state constants.
- Sub-module nd_hs_sync: parameterless 2-flop synchroniser with async active-low reset, instantiated three times.
- calc_redun is reused only when NS_ND_REDUN_CHK_EN is set.

Test Plan:
- OPER_1=GT, REF_VAL_1=2, dst=3, dat=5 -> exactly one o0 transaction, fields equal the input, o1_req_out stays 0.
- Same config, dst=1 -> transaction on o1 only. dst=2 (boundary) -> o1.
- IS_RANGE=true, GT 1 AND LT 4, dst sweep 0..5 -> dst 2,3 to o0; dst 0,1,4,5 to o1. Per-output data order preserved.
- Hold o0_ack_in low for 50 clk while upstream sends a second message -> first upstream handshake completes. Second capture stalls (i0_ack_out=0) until o0 completes, then forwards. Nothing lost or duplicated.
- Assert reset low while o1_req_out=1 -> all req/ack outputs 0 asynchronously. After release, the next message routes normally.
- NS_ND_REDUN_CHK_EN, corrupt red by +1 -> upstream acked, no output req, err_redun=1 and sticky until reset.
